// File: rtl/fractal_pkg.sv
// Shared definitions for the Mandelbrot engine: lane FSM states,
// coordinate format defaults, solver result width and screen size.
package fractal_pkg;

    localparam int DEFAULT_COORD_W = 27;
    localparam int COORD_FRAC_W    = 23;
    localparam int SOLVER_RES_W    = 32;
    localparam int SOLVER_MAX_ITER = 1024;
    localparam int SCREEN_COLUMNS  = 640;
    localparam int SCREEN_ROWS     = 480;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SOLVE = 2'd1,
        ST_EMIT  = 2'd2,
        ST_DONE  = 2'd3
    } lane_state_t;

endpackage

// File: rtl/mand_solver.sv
// Iterative Mandelbrot solver: one z = z^2 + c step per cycle in signed
// fixed point.  Held in reset between pixels; raises out_ready (sticky
// until reset) with the escape iteration count, or MAX_ITER if none.
module mand_solver
    import fractal_pkg::*;
#(
    parameter int COORD_W  = DEFAULT_COORD_W,
    parameter int FRAC_W   = COORD_FRAC_W,
    parameter int MAX_ITER = SOLVER_MAX_ITER
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [COORD_W-1:0]      c_re,
    input  logic [COORD_W-1:0]      c_im,
    output logic                    out_ready,
    output logic [SOLVER_RES_W-1:0] out
);

    logic signed [31:0]       zr_q, zr_d, zi_q, zi_d;
    logic [31:0]              iter_q, iter_d;
    logic                     ready_q, ready_d;
    logic [SOLVER_RES_W-1:0]  out_q, out_d;
    logic signed [63:0]       zr_w, zi_w, cr_w, ci_w, zr_sq, zi_sq, zri;

    // One iteration per cycle; z lives in 32 bits so |z| <= 2 plus c never wraps.
    always_comb begin
        zr_w    = 64'(zr_q);
        zi_w    = 64'(zi_q);
        cr_w    = 64'($signed(c_re));
        ci_w    = 64'($signed(c_im));
        zr_sq   = (zr_w * zr_w) >>> FRAC_W;
        zi_sq   = (zi_w * zi_w) >>> FRAC_W;
        zri     = (zr_w * zi_w) >>> FRAC_W;
        zr_d    = zr_q;
        zi_d    = zi_q;
        iter_d  = iter_q;
        ready_d = ready_q;
        out_d   = out_q;
        if (!ready_q) begin
            if ((zr_sq + zi_sq > (64'sd4 <<< FRAC_W)) || (iter_q == 32'(MAX_ITER))) begin
                ready_d = 1'b1;
                out_d   = iter_q;
            end else begin
                zr_d   = 32'(zr_sq - zi_sq + cr_w);
                zi_d   = 32'((zri <<< 1) + ci_w);
                iter_d = iter_q + 32'd1;
            end
        end
    end

    // Solver state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            zr_q    <= '0;
            zi_q    <= '0;
            iter_q  <= '0;
            ready_q <= 1'b0;
            out_q   <= '0;
        end else begin
            zr_q    <= zr_d;
            zi_q    <= zi_d;
            iter_q  <= iter_d;
            ready_q <= ready_d;
            out_q   <= out_d;
        end
    end

    assign out_ready = ready_q;
    assign out       = out_q;

endmodule

// File: rtl/raster_stepper.sv
// Interleaved raster walker: holds pixel coordinate and column/row counters
// for one lane, advancing one pixel per step and flagging the frame's last
// pixel.  Counters stay on the last legal row once the frame is exhausted.
module raster_stepper
    import fractal_pkg::*;
#(
    parameter int SOLVER_ID   = 0,
    parameter int NUM_SOLVERS = 1,
    parameter int NUM_COLUMNS = SCREEN_COLUMNS,
    parameter int NUM_ROWS    = SCREEN_ROWS,
    parameter int COORD_W     = DEFAULT_COORD_W,
    parameter int COL_W       = 10,
    parameter int ROW_W       = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic [COORD_W-1:0] min_x,
    input  logic [COORD_W-1:0] min_y,
    input  logic [COORD_W-1:0] dx,
    input  logic [COORD_W-1:0] dy,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [COL_W-1:0]   col,
    output logic [ROW_W-1:0]   row,
    output logic               last
);

    logic [COORD_W-1:0] x_q, x_d, y_q, y_d, min_x_q, min_x_d, dx_q, dx_d, ystep_q, ystep_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               last_q, last_d;
    logic               wrap, final_row;

    // Load latches the frame origin; step moves to the next pixel in raster order.
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        min_x_d   = min_x_q;
        dx_d      = dx_q;
        ystep_d   = ystep_q;
        col_d     = col_q;
        row_d     = row_q;
        last_d    = last_q;
        wrap      = (col_q == COL_W'(NUM_COLUMNS - 1));
        final_row = (int'(row_q) + NUM_SOLVERS >= NUM_ROWS);
        if (load) begin
            x_d     = min_x;
            y_d     = min_y + COORD_W'(SOLVER_ID) * dy;
            min_x_d = min_x;
            dx_d    = dx;
            ystep_d = COORD_W'(NUM_SOLVERS) * dy;
            col_d   = '0;
            row_d   = ROW_W'(SOLVER_ID);
            last_d  = 1'b0;
        end else if (step) begin
            last_d = wrap && final_row;
            if (wrap) begin
                col_d = '0;
                x_d   = min_x_q;
                if (!final_row) begin
                    row_d = row_q + ROW_W'(NUM_SOLVERS);
                    y_d   = y_q + ystep_q;
                end
            end else begin
                col_d = col_q + COL_W'(1);
                x_d   = x_q + dx_q;
            end
        end
    end

    // Stepper registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            x_q     <= '0;
            y_q     <= '0;
            min_x_q <= '0;
            dx_q    <= '0;
            ystep_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            min_x_q <= min_x_d;
            dx_q    <= dx_d;
            ystep_q <= ystep_d;
            col_q   <= col_d;
            row_q   <= row_d;
            last_q  <= last_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign col  = col_q;
    assign row  = row_q;
    assign last = last_q;

endmodule

// File: rtl/lane_raster_solver.sv
// Per-lane raster driver: walks the lane's interleaved rows, runs one
// mand_solver per pixel and emits quantised results on a valid/ready stream.
// Stream: a pixel transfers on a cycle where pix_valid && pix_ready; while
// pix_valid is high and pix_ready low, pix_value/col/row are held stable.
module lane_raster_solver
    import fractal_pkg::*;
#(
    parameter int SOLVER_ID   = 0,
    parameter int NUM_SOLVERS = 1,
    parameter int NUM_COLUMNS = SCREEN_COLUMNS,
    parameter int NUM_ROWS    = SCREEN_ROWS,
    parameter int COORD_W     = DEFAULT_COORD_W,
    parameter int COL_W       = 10,
    parameter int ROW_W       = 10,
    parameter int OUT_W       = 4,
    parameter int OUT_SHIFT   = 6,
    parameter int SATURATE    = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [COORD_W-1:0] min_x,
    input  logic [COORD_W-1:0] min_y,
    input  logic [COORD_W-1:0] dx,
    input  logic [COORD_W-1:0] dy,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [OUT_W-1:0]   pix_value,
    output logic [COL_W-1:0]   pix_col,
    output logic [ROW_W-1:0]   pix_row,
    output logic               busy,
    output logic               done
);

    localparam bit LANE_EMPTY = (SOLVER_ID >= NUM_ROWS);

    lane_state_t             state_q, state_d;
    logic                    pix_valid_q, pix_valid_d, busy_q, busy_d, done_q, done_d;
    logic [OUT_W-1:0]        pix_value_q, pix_value_d, quant;
    logic [COL_W-1:0]        pix_col_q, pix_col_d, col;
    logic [ROW_W-1:0]        pix_row_q, pix_row_d, row;
    logic [COORD_W-1:0]      x, y;
    logic                    load, step, last;
    logic                    solver_rst, solver_ready;
    logic [SOLVER_RES_W-1:0] solver_out, res_upper;

    // Solver restarts from scratch for every pixel: it runs only in SOLVE.
    assign solver_rst = reset | (state_q != ST_SOLVE);

    raster_stepper #(
        .SOLVER_ID(SOLVER_ID), .NUM_SOLVERS(NUM_SOLVERS), .NUM_COLUMNS(NUM_COLUMNS),
        .NUM_ROWS(NUM_ROWS), .COORD_W(COORD_W), .COL_W(COL_W), .ROW_W(ROW_W)
    ) u_stepper (
        .clock(clock), .reset(reset), .load(load), .step(step),
        .min_x(min_x), .min_y(min_y), .dx(dx), .dy(dy),
        .x(x), .y(y), .col(col), .row(row), .last(last)
    );

    mand_solver #(.COORD_W(COORD_W)) u_solver (
        .clock(clock), .reset(solver_rst), .c_re(x), .c_im(y),
        .out_ready(solver_ready), .out(solver_out)
    );

    // Quantise the solver result: negative -> 0, overflow -> all-ones or truncate.
    always_comb begin
        res_upper = solver_out >> (OUT_SHIFT + OUT_W);
        if (solver_out[SOLVER_RES_W-1]) begin
            quant = '0;
        end else if ((SATURATE != 0) && (res_upper != '0)) begin
            quant = '1;
        end else begin
            quant = solver_out[OUT_SHIFT +: OUT_W];
        end
    end

    // Next-state and output logic; abort outranks start and the handshake.
    always_comb begin
        state_d     = state_q;
        pix_valid_d = pix_valid_q;
        pix_value_d = pix_value_q;
        pix_col_d   = pix_col_q;
        pix_row_d   = pix_row_q;
        busy_d      = busy_q;
        done_d      = done_q;
        load        = 1'b0;
        step        = 1'b0;
        if (abort) begin
            state_d     = ST_IDLE;
            pix_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        load = 1'b1;
                        if (LANE_EMPTY) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = ST_SOLVE;
                            done_d  = 1'b0;
                            busy_d  = 1'b1;
                        end
                    end
                end
                ST_SOLVE: begin
                    if (solver_ready) begin
                        pix_value_d = quant;
                        pix_col_d   = col;
                        pix_row_d   = row;
                        pix_valid_d = 1'b1;
                        step        = 1'b1;
                        state_d     = ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (pix_ready) begin
                        pix_valid_d = 1'b0;
                        if (last) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = ST_SOLVE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Lane state and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pix_valid_q <= 1'b0;
            pix_value_q <= '0;
            pix_col_q   <= '0;
            pix_row_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_valid_q <= pix_valid_d;
            pix_value_q <= pix_value_d;
            pix_col_q   <= pix_col_d;
            pix_row_q   <= pix_row_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign pix_valid = pix_valid_q;
    assign pix_value = pix_value_q;
    assign pix_col   = pix_col_q;
    assign pix_row   = pix_row_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
